// File: rtl/expr_pkg.sv
// Shared types and constants for the arithmetic-expression stream recogniser.
// Holds the recogniser state enum, the character-class enum and the ASCII
// codes that the classifier decodes.
package expr_pkg;

    // Recogniser states
    typedef enum logic [1:0] {
        S_OPND = 2'd0,  // expecting an operand start
        S_NUM  = 2'd1,  // inside a number
        S_RP   = 2'd2,  // just closed a parenthesis
        S_ERR  = 2'd3   // absorbing error
    } state_e;

    // Character classes
    typedef enum logic [2:0] {
        CC_DIGIT = 3'd0,
        CC_OP    = 3'd1,
        CC_LP    = 3'd2,
        CC_RP    = 3'd3,
        CC_OTHER = 3'd4
    } cclass_e;

    // ASCII codes
    localparam logic [7:0] CH_0     = 8'h30;
    localparam logic [7:0] CH_9     = 8'h39;
    localparam logic [7:0] CH_PLUS  = 8'h2B;
    localparam logic [7:0] CH_MINUS = 8'h2D;
    localparam logic [7:0] CH_MUL   = 8'h2A;
    localparam logic [7:0] CH_DIV   = 8'h2F;
    localparam logic [7:0] CH_LP    = 8'h28;
    localparam logic [7:0] CH_RP    = 8'h29;

endpackage

// File: rtl/char_classify.sv
// Combinational ASCII character classifier.
// Ports:
//   ch_i  [7:0] - ASCII character
//   cls_o       - character class (digit, operator, '(', ')', other)
module char_classify
    import expr_pkg::*;
(
    input  logic [7:0] ch_i,
    output cclass_e    cls_o
);

    // Digits are a contiguous range; the rest are single codes
    always_comb begin
        cls_o = CC_OTHER;
        if (ch_i >= CH_0 && ch_i <= CH_9) begin
            cls_o = CC_DIGIT;
        end else begin
            case (ch_i)
                CH_PLUS, CH_MINUS, CH_MUL, CH_DIV: cls_o = CC_OP;
                CH_LP:                             cls_o = CC_LP;
                CH_RP:                             cls_o = CC_RP;
                default:                           cls_o = CC_OTHER;
            endcase
        end
    end

endmodule

// File: rtl/expr_recognizer.sv
// Streaming recogniser for arithmetic expressions with multi-digit operands,
// + - * / operators and nested parentheses. One character per in_valid edge.
// Ports:
//   clk       - clock, rising edge
//   clr       - asynchronous active-high clear
//   in [7:0]  - ASCII character
//   in_valid  - character on in is consumed at this edge
//   out       - string so far is a complete, valid expression (registered)
//   err       - sticky error (registered)
//   depth     - open-parenthesis count (registered, frozen on error)
module expr_recognizer
    import expr_pkg::*;
#(
    parameter int unsigned MAX_DIGITS = 4,
    parameter int unsigned MAX_DEPTH  = 7,
    parameter int unsigned DEPTH_W    = $clog2(MAX_DEPTH + 1)
) (
    input  logic               clk,
    input  logic               clr,
    input  logic [7:0]         in,
    input  logic               in_valid,
    output logic               out,
    output logic               err,
    output logic [DEPTH_W-1:0] depth
);

    localparam int unsigned CNT_W = $clog2(MAX_DIGITS + 1);
    localparam logic [CNT_W-1:0]   CNT_MAX   = CNT_W'(MAX_DIGITS);
    localparam logic [DEPTH_W-1:0] DEPTH_MAX = DEPTH_W'(MAX_DEPTH);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [DEPTH_W-1:0] depth_q, depth_d;
    logic               out_q, out_d;
    logic               err_q, err_d;
    cclass_e            cls;

    char_classify u_classify (
        .ch_i  (in),
        .cls_o (cls)
    );

    // State register
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q <= S_OPND;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, digit count and depth; everything holds without in_valid
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        depth_d = depth_q;
        if (in_valid) begin
            case (state_q)
                S_OPND: begin
                    if (cls == CC_DIGIT) begin
                        state_d = S_NUM;
                        cnt_d   = CNT_W'(1);
                    end else if (cls == CC_LP && depth_q < DEPTH_MAX) begin
                        depth_d = depth_q + DEPTH_W'(1);
                    end else begin
                        state_d = S_ERR;
                    end
                end
                S_NUM: begin
                    if (cls == CC_DIGIT && cnt_q < CNT_MAX) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end else if (cls == CC_OP) begin
                        state_d = S_OPND;
                        cnt_d   = '0;
                    end else if (cls == CC_RP && depth_q != '0) begin
                        state_d = S_RP;
                        cnt_d   = '0;
                        depth_d = depth_q - DEPTH_W'(1);
                    end else begin
                        state_d = S_ERR;
                    end
                end
                S_RP: begin
                    if (cls == CC_OP) begin
                        state_d = S_OPND;
                    end else if (cls == CC_RP && depth_q != '0) begin
                        depth_d = depth_q - DEPTH_W'(1);
                    end else begin
                        state_d = S_ERR;
                    end
                end
                S_ERR: begin
                    state_d = S_ERR;
                end
                default: begin
                    state_d = S_ERR;
                end
            endcase
        end
    end

    // Output decode from the next state so the flops carry the result of
    // the character accepted at this edge
    always_comb begin
        out_d = 1'b0;
        err_d = (state_d == S_ERR);
        if ((state_d == S_NUM || state_d == S_RP) && depth_d == '0) begin
            out_d = 1'b1;
        end
    end

    // Counter and output registers
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            cnt_q   <= '0;
            depth_q <= '0;
            out_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            depth_q <= depth_d;
            out_q   <= out_d;
            err_q   <= err_d;
        end
    end

    assign out   = out_q;
    assign err   = err_q;
    assign depth = depth_q;

endmodule

// File: tb/tb_expr_recognizer.sv
// Self-checking bench for expr_recognizer (MAX_DIGITS=4, MAX_DEPTH=7).
// Each driven character pushes its expected {out, err, depth} into a
// scoreboard queue; the entry is popped and compared after the edge.
module tb_expr_recognizer;

    localparam int unsigned DEPTH_W = 3;

    typedef struct {
        string tag;
        logic  out;
        logic  err;
        int    depth;
    } exp_t;

    logic               clk;
    logic               clr;
    logic [7:0]         in;
    logic               in_valid;
    logic               out;
    logic               err;
    logic [DEPTH_W-1:0] depth;

    int   checks;
    int   failures;
    int   n_sent;
    exp_t sb[$];

    expr_recognizer #(
        .MAX_DIGITS (4),
        .MAX_DEPTH  (7)
    ) dut (
        .clk      (clk),
        .clr      (clr),
        .in       (in),
        .in_valid (in_valid),
        .out      (out),
        .err      (err),
        .depth    (depth)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp_v);
        checks++;
        if (obs != exp_v) begin
            failures++;
            $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    task automatic compare_one();
        exp_t e;
        if (sb.size() == 0) begin
            check("scoreboard_empty", 1, 0);
        end else begin
            e = sb.pop_front();
            check({e.tag, ".out"},   int'(out),   int'(e.out));
            check({e.tag, ".err"},   int'(err),   int'(e.err));
            check({e.tag, ".depth"}, int'(depth), e.depth);
        end
    endtask

    task automatic send(input logic [7:0] c, input logic eo, input logic ee,
                        input int ed);
        exp_t e;
        @(negedge clk);
        in       = c;
        in_valid = 1'b1;
        e.tag    = $sformatf("chr%0d_x%02h", n_sent, c);
        e.out    = eo;
        e.err    = ee;
        e.depth  = ed;
        sb.push_back(e);
        n_sent++;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        compare_one();
    endtask

    task automatic idle(input logic [7:0] c, input logic eo, input logic ee,
                        input int ed);
        exp_t e;
        @(negedge clk);
        in       = c;
        in_valid = 1'b0;
        e.tag    = $sformatf("idle%0d", n_sent);
        e.out    = eo;
        e.err    = ee;
        e.depth  = ed;
        sb.push_back(e);
        n_sent++;
        @(posedge clk);
        #1;
        compare_one();
    endtask

    task automatic pulse_clr();
        @(negedge clk);
        clr = 1'b1;
        #2;
        clr = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        string s;
        int    eo_a[12];
        int    ed_a[12];
        checks   = 0;
        failures = 0;
        n_sent   = 0;
        clr      = 1'b1;
        in       = 8'h00;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset.out",   int'(out),   0);
        check("reset.err",   int'(err),   0);
        check("reset.depth", int'(depth), 0);
        @(negedge clk);
        clr = 1'b0;

        // Digit run up to and past MAX_DIGITS
        pulse_clr();
        for (int i = 0; i < 4; i++) send("9", 1'b1, 1'b0, 0);
        send("9", 1'b0, 1'b1, 0);

        // Leading zeros form one operand
        pulse_clr();
        send("0", 1'b1, 1'b0, 0);
        send("0", 1'b1, 1'b0, 0);
        send("7", 1'b1, 1'b0, 0);

        // Nested expression
        pulse_clr();
        s    = "(1+(23*4))-5";
        eo_a = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1};
        ed_a = '{1, 1, 1, 2, 2, 2, 2, 2, 1, 0, 0, 0};
        for (int i = 0; i < 12; i++) send(s[i], eo_a[i] != 0, 1'b0, ed_a[i]);

        // Depth overflow on the eighth '('
        pulse_clr();
        for (int i = 1; i <= 7; i++) send("(", 1'b0, 1'b0, i);
        send("(", 1'b0, 1'b1, 7);

        // Maximum nesting fully closed
        pulse_clr();
        for (int i = 1; i <= 7; i++) send("(", 1'b0, 1'b0, i);
        send("1", 1'b0, 1'b0, 7);
        for (int i = 6; i >= 0; i--) send(")", i == 0, 1'b0, i);

        // Illegal sequences
        pulse_clr();
        send("1", 1'b1, 1'b0, 0);
        send("+", 1'b0, 1'b0, 0);
        pulse_clr();
        send(")", 1'b0, 1'b1, 0);
        pulse_clr();
        send("(", 1'b0, 1'b0, 1);
        send(")", 1'b0, 1'b1, 1);
        pulse_clr();
        send("1", 1'b1, 1'b0, 0);
        send(8'h20, 1'b0, 1'b1, 0);
        send("2", 1'b0, 1'b1, 0);
        pulse_clr();
        send("1", 1'b1, 1'b0, 0);
        send("+", 1'b0, 1'b0, 0);
        send("+", 1'b0, 1'b1, 0);
        pulse_clr();
        send("(", 1'b0, 1'b0, 1);
        send("1", 1'b0, 1'b0, 1);
        send(")", 1'b1, 1'b0, 0);
        send("2", 1'b0, 1'b1, 0);

        // Handshake: outputs hold while in_valid is low
        pulse_clr();
        send("1", 1'b1, 1'b0, 0);
        for (int i = 0; i < 5; i++) idle("+", 1'b1, 1'b0, 0);
        send("+", 1'b0, 1'b0, 0);

        // Clear held over an edge overrides in_valid
        @(negedge clk);
        clr      = 1'b1;
        in       = "5";
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        check("clr_hold.out",   int'(out),   0);
        check("clr_hold.err",   int'(err),   0);
        check("clr_hold.depth", int'(depth), 0);
        @(negedge clk);
        clr      = 1'b0;
        in_valid = 1'b0;
        send("5", 1'b1, 1'b0, 0);

        // Asynchronous clear between edges while in error at depth 3
        pulse_clr();
        for (int i = 1; i <= 3; i++) send("(", 1'b0, 1'b0, i);
        send("x", 1'b0, 1'b1, 3);
        @(negedge clk);
        #1;
        clr = 1'b1;
        #1;
        check("async_clr.out",   int'(out),   0);
        check("async_clr.err",   int'(err),   0);
        check("async_clr.depth", int'(depth), 0);
        #1;
        clr = 1'b0;
        send("8", 1'b1, 1'b0, 0);

        check("scoreboard_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
